mcycle_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the processor datapath. It accepts a start request from the condition unit's `MStart` output, which is already gated by the condition check. It then runs an iterative shift-add multiply or restoring divide over `WIDTH` cycles and returns a double-width product or a quotient/remainder pair. `Busy` stalls the pipeline while the operation is in flight; `Done` marks the cycle the results become valid.

---
 rtl/mcycle_ctrl_if.sv | 25 ++
 rtl/mcycle_ctrl.sv | 126 ++++++++++++
 tb/tb_mcycle_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mcycle_ctrl_if.sv
// Purpose: request/result bundle between the pipeline and the multi-cycle mul/div sequencer.
// Latency: none, plain wires.
// Backpressure: Busy from the slave stalls the requester; there is no other flow control.
interface mcycle_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             MStart;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output MStart, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  MStart, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
endinterface

// File: rtl/mcycle_ctrl.sv
// Purpose: iterative shift-add multiply / restoring divide, signed or unsigned, one bit per cycle.
// Latency: WIDTH+1 cycles from the MStart cycle to the Done pulse, for every op.
// Backpressure: Busy is raised combinationally in the start cycle and held through COMPUTE.
module mcycle_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic        CLK,
    input  logic        Reset,
    mcycle_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               op_div;     // latched op class: 1 = divide
    logic               neg_q;      // product/quotient must be negated
    logic               neg_r;      // remainder takes the dividend's (negative) sign
    logic               div0;       // divisor was zero
    logic [WIDTH-1:0]   mreg;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;        // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   res1, res2;
    logic [WIDTH-1:0]   fin1, fin2;

    logic               start, last;
    logic               sgn, s1, s2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod;

    assign start = ((state == IDLE) || (state == DONE)) && bus.MStart;
    assign last  = (state == COMPUTE) && (cnt == CW'(WIDTH - 1));

    // Operand magnitudes and signs, only meaningful in the start cycle
    assign sgn  = bus.MCycleOp[0];
    assign s1   = sgn & bus.Operand1[WIDTH-1];
    assign s2   = sgn & bus.Operand2[WIDTH-1];
    assign mag1 = s1 ? -bus.Operand1 : bus.Operand1;
    assign mag2 = s2 ? -bus.Operand2 : bus.Operand2;

    // Busy must drop the instant Reset is asserted, even with MStart still high
    assign bus.Busy    = (start || (state == COMPUTE)) && !Reset;
    assign bus.Done    = (state == DONE);
    assign bus.Result1 = res1;
    assign bus.Result2 = res2;

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: DONE is a one-cycle stop unless a new start arrives in it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COMPUTE;
            COMPUTE: if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? COMPUTE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration of the unsigned core on the magnitudes
    always_comb begin
        acc_nxt = acc;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        if (!op_div) begin
            sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mreg};
            if (acc[0]) acc_nxt = {sum, acc[WIDTH-1:1]};
            else        acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
        end else begin
            shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            diff    = {1'b0, shifted} - {2'b00, mreg};
            if (!diff[WIDTH+1]) acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up and divide-by-zero override applied to the final iteration
    always_comb begin
        prod = neg_q ? -acc_nxt : acc_nxt;
        fin1 = prod[WIDTH-1:0];
        fin2 = prod[2*WIDTH-1:WIDTH];
        if (op_div) begin
            fin1 = div0  ? '1 : (neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0]);
            fin2 = neg_r ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
        end
    end

    // Operand latch, iteration and result write-back
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cnt    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            mreg   <= '0;
            acc    <= '0;
            res1   <= '0;
            res2   <= '0;
        end else if (start) begin
            cnt    <= '0;
            op_div <= bus.MCycleOp[1];
            neg_q  <= s1 ^ s2;
            neg_r  <= s1;
            div0   <= bus.MCycleOp[1] && (bus.Operand2 == '0);
            mreg   <= bus.MCycleOp[1] ? mag2 : mag1;
            acc    <= {{WIDTH{1'b0}}, (bus.MCycleOp[1] ? mag1 : mag2)};
        end else if (state == COMPUTE) begin
            cnt <= cnt + CW'(1);
            acc <= acc_nxt;
            if (last) begin
                res1 <= fin1;
                res2 <= fin2;
            end
        end
    end
endmodule

// File: tb/tb_mcycle_ctrl.sv
// Purpose: randomized and directed stimulus for mcycle_ctrl against an arithmetic reference model.
// Latency: checks Busy/Done on every cycle of each op, results at cycle WIDTH+1.
// Backpressure: bench honours Busy by only issuing in idle or Done cycles.
module tb_mcycle_ctrl;
    localparam int W = 32;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;

    mcycle_ctrl_if #(.WIDTH(W)) bus();

    mcycle_ctrl #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] held1 = '0, held2 = '0;
    logic [W-1:0] exp1, exp2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    endtask

    // Reference: returns {Result2, Result1} from plain arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        case (op)
            2'd0: return {32'b0, a} * {32'b0, b};
            2'd1: return {{32{a[31]}}, a} * {{32{b[31]}}, b};
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'd2) return {a % b, a / b};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sa = a;
                sb = b;
                q  = sa / sb;
                r  = sa % sb;
                return {r, q};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.MStart   = 1'b1;
        bus.MCycleOp = op;
        bus.Operand1 = a;
        bus.Operand2 = b;
        {exp2, exp1} = model(op, a, b);
    endtask

    // Cycle 0 of an op issued from idle
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge CLK); #1;
        drive(op, a, b);
        @(negedge CLK);
        check("busy_c0", bus.Busy, 1);
        check("done_c0", bus.Done, 0);
        check("r1_c0", bus.Result1, held1);
        check("r2_c0", bus.Result2, held2);
    endtask

    // COMPUTE cycles: operands scrambled, optional stray MStart at cycles 5 and 20
    task automatic compute(input bit noise, input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge CLK); #1;
            bus.MStart   = noise && (c == 5 || c == 20);
            bus.MCycleOp = 2'($urandom);
            bus.Operand1 = $urandom;
            bus.Operand2 = $urandom;
            @(negedge CLK);
            check("busy_run", bus.Busy, 1);
            check("done_run", bus.Done, 0);
            check("r1_hold", bus.Result1, held1);
            check("r2_hold", bus.Result2, held2);
        end
    endtask

    // Done cycle, optionally starting the next op in the same cycle
    task automatic finish(input bit chain, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [W-1:0] o1, o2;
        o1 = exp1;
        o2 = exp2;
        @(posedge CLK); #1;
        if (chain) drive(op, a, b);
        else       bus.MStart = 1'b0;
        @(negedge CLK);
        check("done_pulse", bus.Done, 1);
        check("busy_done", bus.Busy, chain);
        check("result1", bus.Result1, o1);
        check("result2", bus.Result2, o2);
        held1 = o1;
        held2 = o2;
    endtask

    task automatic idle();
        @(posedge CLK); #1;
        bus.MStart = 1'b0;
        @(negedge CLK);
        check("done_idle", bus.Done, 0);
        check("busy_idle", bus.Busy, 0);
        check("r1_idle", bus.Result1, held1);
        check("r2_idle", bus.Result2, held2);
    endtask

    task automatic run_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
        issue(op, a, b);
        compute(noise, W);
        finish(1'b0, 2'd0, 32'd0, 32'd0);
        idle();
    endtask

    initial begin
        logic [1:0]  op, op2;
        logic [31:0] a, b, a2, b2;

        bus.MStart   = 1'b0;
        bus.MCycleOp = 2'd0;
        bus.Operand1 = '0;
        bus.Operand2 = '0;
        #2;
        check("rst_r1", bus.Result1, 0);
        check("rst_r2", bus.Result2, 0);
        check("rst_done", bus.Done, 0);
        check("rst_busy", bus.Busy, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;

        // Directed cases
        run_one(2'd0, 32'd7, 32'd6, 1'b0);
        run_one(2'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_one(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_one(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_one(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_one(2'd2, 32'd100, 32'd0, 1'b0);
        run_one(2'd3, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_one(2'd2, 32'd1000, 32'd7, 1'b1);

        // Back-to-back: second op starts in the Done cycle of the first
        issue(2'd1, 32'd12345, 32'hFFFF_FF00);
        compute(1'b0, W);
        finish(1'b1, 2'd3, 32'hFFFF_FF9C, 32'd7);
        compute(1'b0, W);
        finish(1'b0, 2'd0, 32'd0, 32'd0);
        idle();

        // Reset in cycle 10 of 9 x 9
        issue(2'd0, 32'd9, 32'd9);
        compute(1'b0, 9);
        @(posedge CLK); #1;
        bus.MStart = 1'b0;
        Reset = 1'b1;
        #1;
        check("rst_mid_busy", bus.Busy, 0);
        check("rst_mid_done", bus.Done, 0);
        check("rst_mid_r1", bus.Result1, 0);
        check("rst_mid_r2", bus.Result2, 0);
        held1 = '0;
        held2 = '0;
        @(negedge CLK);
        Reset = 1'b0;
        idle();
        run_one(2'd0, 32'd3, 32'd4, 1'b0);

        // Randomized ops, some with stray starts, some chained
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom);
            a  = pick();
            b  = pick();
            issue(op, a, b);
            compute(1'($urandom), W);
            if ($urandom % 4 == 0) begin
                op2 = 2'($urandom);
                a2  = pick();
                b2  = pick();
                finish(1'b1, op2, a2, b2);
                compute(1'($urandom), W);
            end
            finish(1'b0, 2'd0, 32'd0, 32'd0);
            idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
